// File: rtl/iscbdiv_pkg.sv
// Shared parameters, lane state layout, reset constants and per-stage helper
// functions for the multi-channel correlated stochastic divider.
package iscbdiv_pkg;

    localparam int NCH           = 4;
    localparam int DEP_ABS       = 3;
    localparam int DEP_B2U       = 3;
    localparam int DEP_KERNEL    = 2;
    localparam int DEPLOG_KERNEL = 1;
    localparam int DEP_SYNC      = 2;
    localparam int SYNC_W        = $clog2(DEP_SYNC + 1);

    localparam logic [DEP_ABS-1:0] SC_HALF = {1'b1, {(DEP_ABS-1){1'b0}}};
    localparam logic [DEP_ABS-1:0] SC_MAX  = {DEP_ABS{1'b1}};
    localparam logic [SYNC_W-1:0]  C_MAX   = SYNC_W'(DEP_SYNC);

    // B2U arithmetic is done one bit wider than the accumulator so the
    // +/-1 step can be clamped before it is stored.
    localparam logic signed [DEP_B2U+1:0] B2U_ONE  = (DEP_B2U+2)'(1);
    localparam logic signed [DEP_B2U+1:0] B2U_ZERO = '0;
    localparam logic signed [DEP_B2U+1:0] B2U_MAX  = (DEP_B2U+2)'((2**DEP_B2U) - 1);
    localparam logic signed [DEP_B2U+1:0] B2U_MIN  = (DEP_B2U+2)'(-(2**DEP_B2U));

    typedef struct packed {
        logic [DEP_ABS-1:0]        sc_dvd;
        logic [DEP_ABS-1:0]        sc_dvs;
        logic signed [DEP_B2U:0]   acc_dvd;
        logic signed [DEP_B2U:0]   acc_dvs;
        logic [SYNC_W-1:0]         c;
        logic [DEP_KERNEL-1:0]     tr;
        logic                      g;
    } lane_state_t;

    localparam lane_state_t LANE_RST = '{
        sc_dvd:  SC_HALF,
        sc_dvs:  SC_HALF,
        acc_dvd: '0,
        acc_dvs: '0,
        c:       '0,
        tr:      '0,
        g:       1'b0
    };

    typedef struct packed {
        logic                    u;
        logic signed [DEP_B2U:0] acc;
    } b2u_t;

    function automatic logic [DEP_ABS-1:0] sc_step(input logic [DEP_ABS-1:0] v,
                                                   input logic up);
        if (up)
            return (v == SC_MAX) ? v : v + DEP_ABS'(1);
        else
            return (v == '0) ? v : v - DEP_ABS'(1);
    endfunction

    function automatic b2u_t b2u_step(input logic signed [DEP_B2U:0] acc,
                                      input logic a);
        logic signed [DEP_B2U+1:0] t;
        b2u_t r;
        t = (DEP_B2U+2)'(acc) + (a ? B2U_ONE : -B2U_ONE);
        if (t > B2U_MAX)
            t = B2U_MAX;
        else if (t < B2U_MIN)
            t = B2U_MIN;
        r.u   = (t >= B2U_ONE);
        r.acc = (DEP_B2U+1)'(t - (r.u ? B2U_ONE : B2U_ZERO));
        return r;
    endfunction

endpackage

// File: rtl/iscbdiv_lane.sv
// One divider lane: sign extraction, B2U, correlation sync, trace-replay
// kernel, U2B and sign restoration, with a synchronous flush to reset state.
module iscbdiv_lane
    import iscbdiv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     flush_i,
    input  logic                     mode_bi_i,
    input  logic [DEPLOG_KERNEL-1:0] rand_num_i,
    input  logic                     dividend_i,
    input  logic                     divisor_i,
    output logic                     quotient_o
);

    lane_state_t st_q, st_d, st_n;
    logic        q_q, q_d;

    logic s_dvd, s_dvs, u_dvd, u_dvs, xs, k, out;
    b2u_t b_dvd, b_dvs;

    always_comb begin
        st_n  = st_q;
        st_d  = st_q;
        q_d   = q_q;
        s_dvd = 1'b0;
        s_dvs = 1'b0;
        b_dvd = '0;
        b_dvs = '0;
        u_dvd = dividend_i;
        u_dvs = divisor_i;
        xs    = dividend_i;
        k     = 1'b0;
        out   = 1'b0;

        if (mode_bi_i) begin
            s_dvd = (st_q.sc_dvd < SC_HALF);
            s_dvs = (st_q.sc_dvs < SC_HALF);
            st_n.sc_dvd  = sc_step(st_q.sc_dvd, dividend_i);
            st_n.sc_dvs  = sc_step(st_q.sc_dvs, divisor_i);
            b_dvd = b2u_step(st_q.acc_dvd, dividend_i ^ s_dvd);
            b_dvs = b2u_step(st_q.acc_dvs, divisor_i ^ s_dvs);
            st_n.acc_dvd = b_dvd.acc;
            st_n.acc_dvs = b_dvs.acc;
            u_dvd = b_dvd.u;
            u_dvs = b_dvs.u;
        end

        // Move dividend ones out of divisor-zero slots into later divisor-one slots.
        if (u_dvd && !u_dvs && (st_q.c < C_MAX)) begin
            xs     = 1'b0;
            st_n.c = st_q.c + SYNC_W'(1);
        end else if (!u_dvd && u_dvs && (st_q.c != '0)) begin
            xs     = 1'b1;
            st_n.c = st_q.c - SYNC_W'(1);
        end else begin
            xs     = u_dvd;
        end

        if (u_dvs) begin
            k       = xs;
            st_n.tr = {st_q.tr[DEP_KERNEL-2:0], xs};
        end else begin
            k       = st_q.tr[rand_num_i];
        end

        if (mode_bi_i) begin
            out = k | st_q.g;
            if (!k)
                st_n.g = ~st_q.g;
        end else begin
            out = k;
        end

        if (flush_i) begin
            st_d = LANE_RST;
            q_d  = 1'b0;
        end else if (en_i) begin
            st_d = st_n;
            q_d  = out ^ s_dvd ^ s_dvs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= LANE_RST;
            q_q  <= 1'b0;
        end else begin
            st_q <= st_d;
            q_q  <= q_d;
        end
    end

    assign quotient_o = q_q;

endmodule

// File: rtl/iscbdiv_mc.sv
// Multi-channel stochastic divider top: registers the encoding mode, detects
// mode changes as flush cycles and fans the controls out to NCH lanes.
module iscbdiv_mc
    import iscbdiv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     mode_bi,
    input  logic [DEPLOG_KERNEL-1:0] randNum,
    input  logic [NCH-1:0]           dividend,
    input  logic [NCH-1:0]           divisor,
    output logic [NCH-1:0]           quotient
);

    logic mode_q;
    logic flush;

    assign flush = (mode_bi != mode_q);

    // mode_q follows mode_bi regardless of en so a flush is never deferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_q <= 1'b0;
        else
            mode_q <= mode_bi;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        iscbdiv_lane u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_i       (en),
            .flush_i    (flush),
            .mode_bi_i  (mode_bi),
            .rand_num_i (randNum),
            .dividend_i (dividend[i]),
            .divisor_i  (divisor[i]),
            .quotient_o (quotient[i])
        );
    end

endmodule

// File: tb/tb_iscbdiv_mc.sv
// Randomized self-checking bench for iscbdiv_mc against a behavioural model.
module tb_iscbdiv_mc;
    import iscbdiv_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n, en, mode_bi;
    logic [DEPLOG_KERNEL-1:0] randNum;
    logic [NCH-1:0]           dividend, divisor, quotient;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iscbdiv_mc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode_bi  (mode_bi),
        .randNum  (randNum),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient)
    );

    // Behavioural model state in plain integers.
    localparam int HALF   = 2**(DEP_ABS-1);
    localparam int SCTOP  = 2**DEP_ABS - 1;
    localparam int ACCTOP = 2**DEP_B2U - 1;
    localparam int ACCBOT = -(2**DEP_B2U);

    int m_sc [2][NCH];
    int m_acc[2][NCH];
    int m_c  [NCH];
    int m_tr [NCH][DEP_KERNEL];
    int m_g  [NCH];
    int m_mq;
    logic [NCH-1:0] m_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            for (int j = 0; j < 2; j++) begin
                m_sc[j][i]  = HALF;
                m_acc[j][i] = 0;
            end
            m_c[i] = 0;
            m_g[i] = 0;
            for (int d = 0; d < DEP_KERNEL; d++) m_tr[i][d] = 0;
        end
        m_q = '0;
    endtask

    task automatic model_step(input logic e, input logic m, input int rn,
                              input logic [NCH-1:0] dvd, input logic [NCH-1:0] dvs);
        int in_b[2], s[2], u[2], t, x, y, xp, k, o;
        if (int'(m) != m_mq) begin
            model_reset();
            m_mq = int'(m);
        end else if (e) begin
            for (int i = 0; i < NCH; i++) begin
                in_b[0] = int'(dvd[i]);
                in_b[1] = int'(dvs[i]);
                for (int j = 0; j < 2; j++) begin
                    if (m) begin
                        s[j] = (m_sc[j][i] < HALF) ? 1 : 0;
                        m_sc[j][i] = clampi(m_sc[j][i] + (in_b[j] ? 1 : -1), 0, SCTOP);
                        t = clampi(m_acc[j][i] + (((in_b[j] ^ s[j]) != 0) ? 1 : -1), ACCBOT, ACCTOP);
                        u[j] = (t >= 1) ? 1 : 0;
                        m_acc[j][i] = t - u[j];
                    end else begin
                        s[j] = 0;
                        u[j] = in_b[j];
                    end
                end
                x = u[0];
                y = u[1];
                if (x == 1 && y == 0 && m_c[i] < DEP_SYNC) begin
                    xp = 0; m_c[i]++;
                end else if (x == 0 && y == 1 && m_c[i] > 0) begin
                    xp = 1; m_c[i]--;
                end else begin
                    xp = x;
                end
                if (y == 1) begin
                    k = xp;
                    for (int d = DEP_KERNEL-1; d > 0; d--) m_tr[i][d] = m_tr[i][d-1];
                    m_tr[i][0] = k;
                end else begin
                    k = m_tr[i][rn];
                end
                if (m) begin
                    o = (k == 1) ? 1 : m_g[i];
                    if (k == 0) m_g[i] = 1 - m_g[i];
                end else begin
                    o = k;
                end
                m_q[i] = ((o ^ (s[0] ^ s[1])) != 0);
            end
        end
    endtask

    task automatic cyc(input logic e, input logic m, input logic [DEPLOG_KERNEL-1:0] rn,
                       input logic [NCH-1:0] dvd, input logic [NCH-1:0] dvs);
        en = e; mode_bi = m; randNum = rn; dividend = dvd; divisor = dvs;
        model_step(e, m, int'(rn), dvd, dvs);
        @(posedge clk);
        #1;
        check("q", 32'(quotient), 32'(m_q));
    endtask

    function automatic logic [NCH-1:0] bern(input int permil);
        logic [NCH-1:0] b;
        for (int i = 0; i < NCH; i++) b[i] = ($urandom_range(0, 999) < permil);
        return b;
    endfunction

    function automatic logic [NCH-1:0] rvec();
        return NCH'($urandom);
    endfunction

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        m_mq = 0;
        #1 check("rst_q", 32'(quotient), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rate_run(input logic m, input int p_dvd, input int p_dvs,
                            input int warm, input int n, output int ones);
        ones = 0;
        for (int i = 0; i < warm; i++)
            cyc(1'b1, m, DEPLOG_KERNEL'($urandom), bern(p_dvd), bern(p_dvs));
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, m, DEPLOG_KERNEL'($urandom), bern(p_dvd), bern(p_dvs));
            ones += int'(quotient[0]);
        end
    endtask

    initial begin
        logic [7:0]     pat;
        logic [2:0]     sync_exp;
        logic [NCH-1:0] held;
        int             ones_a, ones_b, ones_c, ones_d;
        logic           md;

        rst_n = 1'b0; en = 1'b0; mode_bi = 1'b0; randNum = '0;
        dividend = '0; divisor = '0; m_mq = 0;
        model_reset();
        #2 check("rst_q", 32'(quotient), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unipolar pass-through on lane 0 with divisor all ones.
        pat = 8'b1011_0010;
        for (int b = 7; b >= 0; b--) begin
            cyc(1'b1, 1'b0, DEPLOG_KERNEL'($urandom), {rvec() & NCH'(4'hE)} | NCH'(pat[b]), '1);
            check("pass", 32'(quotient[0]), 32'(pat[b]));
        end

        // Sync saturation: four 1/0 pairs then three 0/1 pairs.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DEPLOG_KERNEL'($urandom), '1, '0);
        sync_exp = 3'b110;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, DEPLOG_KERNEL'($urandom), '0, '1);
            check("sync_x", 32'(quotient[0]), 32'(sync_exp[2-i]));
        end

        // Unipolar ratio runs.
        do_reset();
        rate_run(1'b0, 250, 500, 0, 4096, ones_a);
        check("rate_a", 32'((ones_a >= 1884) && (ones_a <= 2212)), 32'd1);
        rate_run(1'b0, 250, 250, 0, 4096, ones_b);
        check("rate_b_gt_a", 32'(ones_b > ones_a), 32'd1);

        // Switch to bipolar: flush cycle clears quotient.
        cyc(1'b1, 1'b1, '0, rvec(), rvec());
        check("flush_q", 32'(quotient), 32'd0);
        rate_run(1'b1, 375, 750, 64, 2048, ones_c);
        check("bi_neg", 32'(ones_c < 1024), 32'd1);
        rate_run(1'b1, 625, 750, 64, 2048, ones_d);
        check("bi_pos", 32'(ones_d > 1024), 32'd1);

        // en=0 freeze, then resume under the model.
        held = quotient;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, DEPLOG_KERNEL'($urandom), rvec(), rvec());
            check("freeze", 32'(quotient), 32'(held));
        end
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, DEPLOG_KERNEL'($urandom), rvec(), rvec());

        // Flush wins over en=0.
        cyc(1'b0, 1'b0, '0, rvec(), rvec());
        check("flush_en0", 32'(quotient), 32'd0);

        // Random mix of enables, mode toggles and distinct per-lane streams.
        md = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 3) md = ~md;
            cyc(($urandom_range(0, 9) != 0), md, DEPLOG_KERNEL'($urandom), rvec(), rvec());
        end

        // Asynchronous reset off the clock edge.
        for (int i = 0; i < 8; i++) cyc(1'b1, md, DEPLOG_KERNEL'($urandom), '1, '1);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 32'(quotient), 32'd0);
        model_reset();
        m_mq = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, DEPLOG_KERNEL'($urandom), rvec(), rvec());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
